wallace_mac_sequencer: RTL

- Sequences the combinational 8x8 Wallace-tree multiplier (exact or approximate reduction layers) to perform multiply-accumulate over a stream of operand pairs.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier inputs from registers.
- Captures the 16-bit product and accumulates a programmed number of terms, then presents the sum over a second valid/ready handshake.
- Sits between the operand source and the Wallace tree multiplier instance; the multiplier remains external.

---
 rtl/wallace_mac_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/wallace_mac_sequencer.sv
// Multiply-accumulate sequencer around an external combinational 8x8 Wallace-tree multiplier.
// Operand pairs stream in over valid/ready; the accumulated sum leaves over a second valid/ready.
module wallace_mac_sequencer #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] terms;
    logic [CNT_W-1:0] cnt;
    logic             s1_valid;
    logic             s2_valid;
    logic [15:0]      prod_reg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic             xfer;
    logic             job_start;

    assign xfer      = in_valid && in_ready;
    assign job_start = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(prod_reg);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (num_terms == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = (cnt < terms);
                if (in_valid && in_ready && (cnt + CNT_W'(1) == terms))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // The last add commits on the edge that clears s2_valid.
                if (!s1_valid && !s2_valid)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            terms    <= '0;
            cnt      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            prod_reg <= '0;
            acc      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            out_sum  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= xfer;
            s2_valid <= s1_valid;
            if (xfer) begin
                mul_a <= in_a;
                mul_b <= in_b;
                cnt   <= cnt + CNT_W'(1);
            end
            if (s1_valid)
                prod_reg <= mul_p;
            if (job_start) begin
                terms    <= num_terms;
                cnt      <= '0;
                acc      <= '0;
                overflow <= 1'b0;
                if (num_terms == '0)
                    out_sum <= '0;
            end else if (s2_valid) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W])
                    overflow <= 1'b1;
            end
            if (state == DRAIN && state_nxt == DONE)
                out_sum <= acc;
        end
    end

endmodule
